// File: rtl/ec_serial_harness.sv
// Serial command/result harness around an EC core: frame in, start pulse, wait done/timeout, frame out.
// Optional even-parity check on the command frame is enabled by defining HARNESS_PARITY_EN.
module ec_serial_harness #(
  parameter int IN_WIDTH  = 242,
  parameter int OUT_WIDTH = 479,
  parameter int TMO_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 test_i,
  output logic                 test_o,
  output logic                 busy,
  output logic                 dut_start,
  output logic [IN_WIDTH-1:0]  dut_din,
  input  logic                 dut_done,
  input  logic [OUT_WIDTH-1:0] dut_dout
);

  localparam int TX_BITS  = OUT_WIDTH + 2;
  localparam int MAX_BITS = (IN_WIDTH > TX_BITS) ? IN_WIDTH : TX_BITS;
  localparam int CW       = $clog2(MAX_BITS + 1);
`ifdef HARNESS_PARITY_EN
  localparam int RX_BITS  = IN_WIDTH + 1;
`else
  localparam int RX_BITS  = IN_WIDTH;
`endif
  // Last WAIT count before the terminal value 2^TMO_W-1 is reached.
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

  typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [IN_WIDTH-1:0]  din_q, din_shift;
  logic [OUT_WIDTH-1:0] cap_q;
  logic                 tmo_q;
  logic                 rx_last, rx_bad;

  assign rx_last   = (bit_cnt == CW'(RX_BITS - 1));
  assign dut_din   = din_q;
  assign dut_start = (state == START);
  assign busy      = (state != IDLE);

`ifdef HARNESS_PARITY_EN
  // On the parity cycle din_q holds all data bits; even parity means zero overall XOR.
  assign rx_bad = ^{din_q, test_i};
`else
  assign rx_bad = 1'b0;
`endif

  always_comb begin
    din_shift = din_q >> 1;
    din_shift[IN_WIDTH-1] = test_i;
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (test_i) state_next = RECV;
      RECV:    if (rx_last) state_next = rx_bad ? SEND : START;
      START:   state_next = WAIT;
      WAIT:    if (dut_done || tmo_cnt == TMO_LAST) state_next = SEND;
      SEND:    if (bit_cnt == CW'(TX_BITS)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
      din_q   <= '0;
      cap_q   <= '0;
      tmo_q   <= 1'b0;
      test_o  <= 1'b0;
    end else begin
      if (state_next != state)
        bit_cnt <= '0;
      else if (state == RECV || state == SEND)
        bit_cnt <= bit_cnt + CW'(1);

      unique case (state)
        RECV: begin
          if (bit_cnt < CW'(IN_WIDTH)) din_q <= din_shift;
          if (rx_last && rx_bad) begin
            cap_q <= '0;
            tmo_q <= 1'b1;
          end
        end
        START: tmo_cnt <= '0;
        WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (state_next == SEND) begin
            cap_q <= dut_dout;
            tmo_q <= !dut_done;  // done wins over a coincident terminal count
          end
        end
        SEND: begin
          // Frame order: start bit, status bit, then the captured result LSB first.
          if (bit_cnt == '0) begin
            test_o <= 1'b1;
          end else if (bit_cnt == CW'(1)) begin
            test_o <= tmo_q;
          end else if (bit_cnt < CW'(TX_BITS)) begin
            test_o <= cap_q[0];
            cap_q  <= cap_q >> 1;
          end else begin
            test_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ec_serial_harness.sv
// Directed scoreboard bench for ec_serial_harness (IN_WIDTH=8, OUT_WIDTH=8, TMO_W=4).
// Parity steps are compiled in when HARNESS_PARITY_EN is defined.
module tb_ec_serial_harness;

  localparam int IW = 8;
  localparam int OW = 8;
  localparam int TW = 4;
  localparam int FW = OW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          test_i = 1'b0;
  logic          test_o, busy, dut_start, dut_done;
  logic [IW-1:0] dut_din;
  logic [OW-1:0] dut_dout = '0;

  typedef struct {
    logic [FW-1:0] frame;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   start_cnt = 0;
  int   done_at = 0;
  int   s0;
  logic armed;
  int   cyc;
`ifdef HARNESS_PARITY_EN
  logic par_err_inj = 1'b0;
`endif

  always #5 clk = ~clk;

  ec_serial_harness #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .test_i(test_i), .test_o(test_o), .busy(busy),
    .dut_start(dut_start), .dut_din(dut_din), .dut_done(dut_done), .dut_dout(dut_dout)
  );

  // Core model: one-cycle done pulse, visible in the (done_at)th WAIT cycle; done_at=0 never answers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cyc <= 0;
      dut_done <= 1'b0;
    end else if (dut_start) begin
      armed <= (done_at != 0);
      cyc <= 1;
      dut_done <= 1'b0;
    end else if (armed) begin
      cyc <= cyc + 1;
      if (cyc == done_at - 1) begin
        dut_done <= 1'b1;
        armed <= 1'b0;
      end
    end else begin
      dut_done <= 1'b0;
    end
  end

  always @(posedge clk) if (dut_start === 1'b1) start_cnt <= start_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FW-1:0] frame_of(input logic tmo, input logic [OW-1:0] d);
    return {d, tmo, 1'b1};
  endfunction

  task automatic push_exp(input logic [FW-1:0] fr, input int lat);
    exp_t e;
    e.frame = fr;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Called on a negedge in IDLE; returns on the negedge after the last RECV bit.
  task automatic send_frame(input logic [IW-1:0] d);
    test_i = 1'b1;
    for (int i = 0; i < IW; i++) begin
      @(negedge clk);
      test_i = d[i];
    end
`ifdef HARNESS_PARITY_EN
    @(negedge clk);
    test_i = (^d) ^ par_err_inj;
`endif
    @(negedge clk);
    test_i = 1'b0;
  endtask

  // Waits for the start bit, reads the whole frame, compares with the oldest expectation.
  task automatic collect(input string tag, input bit noisy);
    exp_t          e;
    logic [FW-1:0] got;
    int            lat;
    lat = 0;
    while (test_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      if (noisy) test_i = ~test_i;
      lat++;
    end
    check({tag, "_start_bit"}, test_o, 1);
    got = '0;
    got[0] = test_o;
    for (int i = 1; i < FW; i++) begin
      @(negedge clk);
      if (noisy) test_i = ~test_i;
      got[i] = test_o;
    end
    e = sb.pop_front();
    check({tag, "_frame"}, got, e.frame);
    if (e.lat >= 0) check({tag, "_latency"}, lat, e.lat);
    @(negedge clk);
    test_i = 1'b0;
    check({tag, "_idle_o"}, test_o, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    #12;
    check("rst_test_o", test_o, 0);
    check("rst_busy", busy, 0);
    check("rst_start", dut_start, 0);
    check("rst_din", dut_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transaction
    s0 = start_cnt;
    done_at = 3;
    dut_dout = 8'h3C;
    push_exp(frame_of(1'b0, 8'h3C), 5);
    send_frame(8'hA5);
    check("basic_din", dut_din, 8'hA5);
    check("basic_start_pulse", dut_start, 1);
    check("basic_busy", busy, 1);
    collect("basic", 1'b0);
    check("basic_starts", start_cnt - s0, 1);
    check("basic_din_hold", dut_din, 8'hA5);

    // Timeout: 15 WAIT cycles then SEND
    done_at = 0;
    dut_dout = 8'hFF;
    push_exp(frame_of(1'b1, 8'hFF), 17);
    send_frame(8'hA5);
    collect("timeout", 1'b0);

    // done arrives on the terminal-count cycle
    done_at = 15;
    dut_dout = 8'h96;
    push_exp(frame_of(1'b0, 8'h96), 17);
    send_frame(8'hA5);
    collect("done_at_tc", 1'b0);

    // test_i toggling during WAIT/SEND, then back-to-back frame
    s0 = start_cnt;
    done_at = 3;
    dut_dout = 8'h5A;
    push_exp(frame_of(1'b0, 8'h5A), 5);
    send_frame(8'hC3);
    collect("noisy", 1'b1);
    check("noisy_starts", start_cnt - s0, 1);
    dut_dout = 8'h81;
    push_exp(frame_of(1'b0, 8'h81), 5);
    send_frame(8'h01);
    check("b2b_din", dut_din, 8'h01);
    collect("b2b", 1'b0);
    check("b2b_starts", start_cnt - s0, 2);

    // Asynchronous reset in the middle of SEND
    done_at = 3;
    dut_dout = 8'hE7;
    send_frame(8'h3C);
    n = 0;
    while (test_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("rst_mid_pre_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_test_o", test_o, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_din", dut_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = start_cnt;
    dut_dout = 8'h42;
    push_exp(frame_of(1'b0, 8'h42), 5);
    send_frame(8'h7E);
    check("post_rst_din", dut_din, 8'h7E);
    collect("post_rst", 1'b0);
    check("post_rst_starts", start_cnt - s0, 1);

`ifdef HARNESS_PARITY_EN
    // Wrong parity: no start, error frame with zero data
    s0 = start_cnt;
    par_err_inj = 1'b1;
    push_exp(frame_of(1'b1, 8'h00), 1);
    send_frame(8'hA5);
    collect("par_bad", 1'b0);
    check("par_bad_starts", start_cnt - s0, 0);
    par_err_inj = 1'b0;
    dut_dout = 8'h3C;
    push_exp(frame_of(1'b0, 8'h3C), 5);
    send_frame(8'hA5);
    check("par_ok_din", dut_din, 8'hA5);
    collect("par_ok", 1'b0);
    check("par_ok_starts", start_cnt - s0, 1);
`endif

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
